// File: rtl/sd_arbiter_pkg.sv
// Shared definitions for the two-port SD sector controller arbiter.
package sd_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_RESET,
    ST_REPORT
  } state_t;

  localparam logic [3:0] ERR_OK      = 4'h0;
  localparam logic [3:0] ERR_TIMEOUT = 4'hF;
  localparam int         TIMER_W     = 25;

endpackage

// File: rtl/sd_arbiter_req_latch.sv
// One requester's front end: captures a request, holds it pending until the
// arbiter reports the outcome, then presents a done strobe and status code.
module sd_arbiter_req_latch (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] lba,
  input  logic        report,
  input  logic [3:0]  code,
  output logic        busy,
  output logic        lat_rw,
  output logic [31:0] lat_lba,
  output logic        done,
  output logic [3:0]  err
);

  // A request arriving while one is pending is dropped; report always wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy    <= 1'b0;
      lat_rw  <= 1'b0;
      lat_lba <= '0;
      done    <= 1'b0;
      err     <= '0;
    end else begin
      done <= report;
      if (report) begin
        busy <= 1'b0;
        err  <= code;
      end else if (req && !busy) begin
        busy    <= 1'b1;
        lat_rw  <= rw;
        lat_lba <= lba;
      end
    end
  end

endmodule

// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing one SD sector controller between the CPU io
// block (port 0) and the boot/DMA loader (port 1), with retry and timeout.
module sd_arbiter
  import sd_arbiter_pkg::*;
#(
  parameter int unsigned RETRIES = 2,
  parameter int unsigned TIMEOUT = 25000000,
  parameter int unsigned RST_LEN = 16,
  parameter int unsigned GAP     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_rw,
  input  logic [31:0] r0_lba,
  output logic        r0_busy,
  output logic        r0_done,
  output logic [3:0]  r0_err,
  input  logic        r1_req,
  input  logic        r1_rw,
  input  logic [31:0] r1_lba,
  output logic        r1_busy,
  output logic        r1_done,
  output logic [3:0]  r1_err,
  output logic        sd_command,
  output logic        sd_rw,
  output logic [31:0] sd_lba,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic [3:0]  sd_error,
  output logic        sd_rst,
  output logic        owner
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP - 1);
  localparam logic [TIMER_W-1:0] RST_CYCLES   = TIMER_W'(RST_LEN);
  localparam logic [3:0]         RETRY_MAX    = 4'(RETRIES);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           attempt_q, attempt_d;
  logic                 rr_q, rr_d, owner_q, owner_d, rw_q, rw_d, grant;
  logic [31:0]          lba_q, lba_d;
  logic                 report_go;
  logic [3:0]           report_code;
  logic                 lat_rw0, lat_rw1;
  logic [31:0]          lat_lba0, lat_lba1;

  sd_arbiter_req_latch u_req_latch0 (
    .clock(clock), .reset(reset), .req(r0_req), .rw(r0_rw), .lba(r0_lba),
    .report(report_go && !owner_q), .code(report_code), .busy(r0_busy),
    .lat_rw(lat_rw0), .lat_lba(lat_lba0), .done(r0_done), .err(r0_err)
  );

  sd_arbiter_req_latch u_req_latch1 (
    .clock(clock), .reset(reset), .req(r1_req), .rw(r1_rw), .lba(r1_lba),
    .report(report_go && owner_q), .code(report_code), .busy(r1_busy),
    .lat_rw(lat_rw1), .lat_lba(lat_lba1), .done(r1_done), .err(r1_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      attempt_q <= '0;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      rw_q      <= 1'b0;
      lba_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      attempt_q <= attempt_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      rw_q      <= rw_d;
      lba_q     <= lba_d;
    end
  end

  // The timer is shared: command timeout in WAIT, spacing in GAP, pulse length in RESET.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    attempt_d   = attempt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    rw_d        = rw_q;
    lba_d       = lba_q;
    grant       = 1'b0;
    report_go   = 1'b0;
    report_code = ERR_OK;
    sd_command  = 1'b0;
    sd_rst      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (r0_busy || r1_busy) begin
          grant     = (r0_busy && r1_busy) ? rr_q : r1_busy;
          rr_d      = ~grant;
          owner_d   = grant;
          rw_d      = grant ? lat_rw1 : lat_rw0;
          lba_d     = grant ? lat_lba1 : lat_lba0;
          attempt_d = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Hold the strobe off while a stray done is on the bus.
        if (!sd_done) begin
          sd_command = 1'b1;
          timer_d    = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        if (sd_done) begin
          if (sd_error == ERR_OK) begin
            report_go = 1'b1;
            state_d   = ST_REPORT;
          end else if (attempt_q < RETRY_MAX) begin
            attempt_d = attempt_q + 4'd1;
            timer_d   = '0;
            state_d   = (GAP == 0) ? ST_ISSUE : ST_GAP;
          end else begin
            report_go   = 1'b1;
            report_code = sd_error;
            state_d     = ST_REPORT;
          end
        end else if (timer_q >= TIMEOUT_LAST) begin
          timer_d = '0;
          state_d = ST_RESET;
        end
      end
      ST_GAP: begin
        if (timer_q >= GAP_LAST) state_d = ST_ISSUE;
        else timer_d = timer_q + 1'b1;
      end
      ST_RESET: begin
        if (timer_q < RST_CYCLES) begin
          sd_rst  = 1'b1;
          timer_d = timer_q + 1'b1;
        end else if (!sd_busy) begin
          report_go   = 1'b1;
          report_code = ERR_TIMEOUT;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign sd_rw  = rw_q;
  assign sd_lba = lba_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_sd_arbiter.sv
// Directed plus randomized bench for sd_arbiter against a behavioural
// controller model and a per-job outcome model.
module tb_sd_arbiter;
  import sd_arbiter_pkg::*;

  localparam int unsigned RETRIES = 2;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned RST_LEN = 16;
  localparam int unsigned GAP     = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_req, r0_rw, r1_req, r1_rw;
  logic [31:0] r0_lba, r1_lba;
  logic        r0_busy, r0_done, r1_busy, r1_done;
  logic [3:0]  r0_err, r1_err;
  logic        sd_command, sd_rw, sd_busy, sd_done, sd_rst, owner;
  logic [31:0] sd_lba;
  logic [3:0]  sd_error;

  always #5 clock = ~clock;

  sd_arbiter #(.RETRIES(RETRIES), .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN), .GAP(GAP)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_lba(r0_lba),
    .r0_busy(r0_busy), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_lba(r1_lba),
    .r1_busy(r1_busy), .r1_done(r1_done), .r1_err(r1_err),
    .sd_command(sd_command), .sd_rw(sd_rw), .sd_lba(sd_lba),
    .sd_busy(sd_busy), .sd_done(sd_done), .sd_error(sd_error),
    .sd_rst(sd_rst), .owner(owner)
  );

  typedef struct {
    int          cyc;
    logic        rw;
    logic [31:0] lba;
    logic        own;
  } cmd_t;

  cmd_t       cmd_q[$];
  int         sdone_q[$];
  logic [3:0] err_script[$], err_plan[$];
  int         cyc, checks, errors;
  int         done_cnt[2], done_cyc[2];
  logic [3:0] done_err[2];
  logic       done_own[2], done_busy[2];
  int         rst_cnt, rst_first;
  bit         ctl_live, ctl_hang;
  int         ctl_due, ctl_lat;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the controller model, then sample and log DUT activity.
  task automatic tick();
    cmd_t c;
    @(posedge clock);
    cyc++;
    #1;
    sd_done  = 1'b0;
    sd_error = 4'h0;
    if (ctl_live && !ctl_hang && cyc == ctl_due) begin
      sd_done  = 1'b1;
      sd_error = (err_script.size() > 0) ? err_script.pop_front() : 4'h0;
      ctl_live = 1'b0;
      sdone_q.push_back(cyc);
    end
    sd_busy = ctl_live;
    #1;
    if (reset) ctl_live = 1'b0;
    if (sd_command) begin
      check_output("cmd_during_rst", {31'b0, sd_rst}, 0);
      check_output("cmd_with_done", {31'b0, sd_done}, 0);
      c.cyc = cyc; c.rw = sd_rw; c.lba = sd_lba; c.own = owner;
      cmd_q.push_back(c);
      ctl_live = 1'b1;
      ctl_due  = cyc + ctl_lat;
    end
    if (sd_rst) begin
      if (rst_first < 0) rst_first = cyc;
      rst_cnt++;
      ctl_live = 1'b0;
    end
    if (r0_done) begin
      done_cnt[0]++; done_cyc[0] = cyc; done_err[0] = r0_err;
      done_own[0] = owner; done_busy[0] = r0_busy;
    end
    if (r1_done) begin
      done_cnt[1]++; done_cyc[1] = cyc; done_err[1] = r1_err;
      done_own[1] = owner; done_busy[1] = r1_busy;
    end
  endtask

  task automatic clear_log();
    cmd_q.delete();
    sdone_q.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst_cnt = 0; rst_first = -1;
  endtask

  task automatic request(input bit port, input logic rw, input logic [31:0] lba);
    if (port) begin r1_req = 1'b1; r1_rw = rw; r1_lba = lba; end
    else      begin r0_req = 1'b1; r0_rw = rw; r0_lba = lba; end
    tick();
    r0_req = 1'b0;
    r1_req = 1'b0;
  endtask

  task automatic wait_done(input bit port, input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (done_cnt[port] < n && k < limit) begin
      tick();
      k++;
    end
    check_output(tag, done_cnt[port], n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ctl"}, {28'b0, sd_command, sd_rst, owner, sd_rw}, 0);
    check_output({tag, "_lba"}, sd_lba, 0);
    check_output({tag, "_ports"}, {20'b0, r0_busy, r0_done, r0_err, r1_busy, r1_done, r1_err}, 0);
  endtask

  // Outcome of one job from the error plan: attempts stop at the first ok or after RETRIES retries.
  function automatic void model_job(output int n_cmd, output logic [3:0] code);
    logic [3:0] e;
    n_cmd = 0;
    code  = 4'h0;
    for (int a = 0; a <= int'(RETRIES); a++) begin
      e     = (a < err_plan.size()) ? err_plan[a] : 4'h0;
      n_cmd = a + 1;
      code  = e;
      if (e == 4'h0) break;
    end
  endfunction

  initial begin
    int          k, n, n_cmd;
    logic [3:0]  code;
    logic [31:0] la, lb;
    bit          port;

    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1;
    r0_req = 1'b0; r0_rw = 1'b0; r0_lba = '0;
    r1_req = 1'b0; r1_rw = 1'b0; r1_lba = '0;
    sd_busy = 1'b0; sd_done = 1'b0; sd_error = 4'h0;
    ctl_live = 1'b0; ctl_hang = 1'b0; ctl_lat = 10;
    clear_log();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Single read, fixed 100-cycle controller latency.
    clear_log();
    ctl_lat = 100;
    request(1'b0, 1'b0, 32'd5);
    k = cyc;
    check_output("t1_busy_rise", {31'b0, r0_busy}, 1);
    wait_done(1'b0, 1, 400, "t1_done");
    check_output("t1_cmds", cmd_q.size(), 1);
    check_output("t1_cmd_cyc", cmd_q[0].cyc, k + 1);
    check_output("t1_lba", cmd_q[0].lba, 5);
    check_output("t1_owner", {31'b0, cmd_q[0].own}, 0);
    check_output("t1_done_cyc", done_cyc[0], sdone_q[0] + 1);
    check_output("t1_err", {28'b0, done_err[0]}, 0);
    check_output("t1_busy_fall", {31'b0, done_busy[0]}, 0);
    tick();

    // Simultaneous requests straight after reset: port 0 first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_log();
    ctl_lat = $urandom_range(5, 30);
    la = $urandom; lb = $urandom;
    r0_req = 1'b1; r0_rw = 1'b0; r0_lba = la;
    r1_req = 1'b1; r1_rw = 1'b1; r1_lba = lb;
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    wait_done(1'b1, 1, 400, "t2_done1");
    check_output("t2_cmds", cmd_q.size(), 2);
    check_output("t2_own0", {31'b0, cmd_q[0].own}, 0);
    check_output("t2_lba0", cmd_q[0].lba, la);
    check_output("t2_own1", {31'b0, cmd_q[1].own}, 1);
    check_output("t2_lba1", cmd_q[1].lba, lb);
    check_output("t2_rw1", {31'b0, cmd_q[1].rw}, 1);
    check_output("t2_done0", done_cnt[0], 1);
    check_output("t2_order", {31'b0, done_cyc[0] < done_cyc[1]}, 1);
    check_output("t2_done_owner1", {31'b0, done_own[1]}, 1);
    tick();

    // Two errors then success: three strobes spaced by GAP.
    clear_log();
    err_plan = '{4'h3, 4'h3, 4'h0};
    err_script = err_plan;
    model_job(n_cmd, code);
    ctl_lat = $urandom_range(5, 30);
    la = $urandom;
    request(1'b0, 1'b1, la);
    wait_done(1'b0, 1, 1000, "t3_done");
    check_output("t3_cmds", cmd_q.size(), n_cmd);
    for (int i = 1; i < cmd_q.size(); i++) begin
      check_output("t3_gap", cmd_q[i].cyc, sdone_q[i-1] + int'(GAP) + 1);
      check_output("t3_relba", cmd_q[i].lba, la);
    end
    check_output("t3_err", {28'b0, done_err[0]}, {28'b0, code});
    tick();

    // Randomized jobs: random error plans, ports, latencies.
    repeat (5) begin
      clear_log();
      err_plan.delete();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++)
        err_plan.push_back(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 14)));
      err_script = err_plan;
      model_job(n_cmd, code);
      port = 1'($urandom_range(0, 1));
      la = $urandom;
      ctl_lat = $urandom_range(2, 20);
      request(port, 1'($urandom_range(0, 1)), la);
      wait_done(port, 1, 1000, "rnd_done");
      check_output("rnd_cmds", cmd_q.size(), n_cmd);
      check_output("rnd_err", {28'b0, done_err[port]}, {28'b0, code});
      check_output("rnd_owner", {31'b0, done_own[port]}, {31'b0, port});
      check_output("rnd_lba", cmd_q[0].lba, la);
      tick();
    end

    // Controller never answers: timeout, reset pulse, status F.
    clear_log();
    err_script.delete();
    ctl_hang = 1'b1;
    request(1'b0, 1'b0, $urandom);
    wait_done(1'b0, 1, TIMEOUT + 200, "t4_done");
    check_output("t4_cmds", cmd_q.size(), 1);
    check_output("t4_rst_start", rst_first, cmd_q[0].cyc + int'(TIMEOUT) + 1);
    check_output("t4_rst_len", rst_cnt, RST_LEN);
    check_output("t4_done_cyc", done_cyc[0], rst_first + int'(RST_LEN) + 1);
    check_output("t4_err", {28'b0, done_err[0]}, {28'b0, ERR_TIMEOUT});
    ctl_hang = 1'b0;
    tick();
    check_output("t4_err_hold", {28'b0, r0_err}, {28'b0, ERR_TIMEOUT});

    // Re-request while busy is ignored, both before and during service.
    clear_log();
    ctl_lat = 40;
    la = $urandom;
    request(1'b1, 1'b1, la);
    request(1'b1, 1'b0, 32'd9);
    repeat (5) tick();
    request(1'b1, 1'b0, 32'd9);
    wait_done(1'b1, 1, 300, "t5_done");
    repeat (100) tick();
    check_output("t5_done_count", done_cnt[1], 1);
    check_output("t5_cmds", cmd_q.size(), 1);
    check_output("t5_lba", cmd_q[0].lba, la);
    check_output("t5_rw", {31'b0, cmd_q[0].rw}, 1);

    // Reset while waiting on the controller, then a clean job.
    clear_log();
    ctl_lat = 200;
    request(1'b0, 1'b1, $urandom);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("t6_reset");
    reset = 1'b0;
    tick();
    clear_log();
    ctl_lat = 20;
    la = $urandom;
    request(1'b0, 1'b0, la);
    wait_done(1'b0, 1, 300, "t6_done");
    check_output("t6_cmds", cmd_q.size(), 1);
    check_output("t6_lba", cmd_q[0].lba, la);
    check_output("t6_err", {28'b0, done_err[0]}, 0);
    check_output("t6_rst", rst_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
